wb_stage_pipe: RTL and testbench
================================

// Module: wb_stage_pipe
// PURPOSE
//  Parametrised write-back stage with its own MEM/WB pipeline register. Captures MEM results
//  on clk, selects the write-back source (ALU, load data, link PC) and drives register-file
//  write port. Adds stall/flush, r0 write suppression and a retired-instruction counter.
//  Sits between the MEM stage and the register file; also feeds the forwarding unit.
// PARAMETERS
//  DATA_W      32  datapath width (multiple of 16)
//  REG_ADDR_W  5   register-file address width
//  CNT_W       32  retired-instruction counter width
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           asynchronous, active-high reset
//  in_valid       in   1           MEM stage presents a valid instruction
//  in_stall       in   1           hold pipeline register contents
//  in_flush       in   1           invalidate pipeline register
//  mem_rdata      in   DATA_W      raw data-memory read word
//  alu_result     in   DATA_W      ALU result / memory address
//  link_pc        in   DATA_W      PC+8 for JAL/JALR
//  rd             in   REG_ADDR_W  destination register
//  reg_write      in   1           instruction writes rd
//  wb_sel         in   2           0=ALU 1=MEM 2=LINK 3=zero
//  load_size      in   2           0=byte 1=half 2=word 3=word
//  load_unsigned  in   1           zero-extend sub-word loads
//  wb_we          out  1           register-file write enable
//  wb_rd          out  REG_ADDR_W  register-file write address
//  wb_data        out  DATA_W      register-file write data
//  wb_valid       out  1           pipeline register holds a valid instruction
//  retired_cnt    out  CNT_W       count of valid instructions accepted
// BEHAVIOUR
//  - Reset (async, active-high): valid=0, all captured fields=0, retired_cnt=0; so
//    wb_we=0, wb_rd=0, wb_data=0, wb_valid=0 immediately, independent of clk.
//  - Register update at posedge clk, priority: flush > stall > load.
//    flush: valid<=0, fields keep value. stall (no flush): all hold. else: capture all
//    inputs, valid<=in_valid.
//  - Latency: 1 cycle from MEM inputs to wb_* outputs; outputs combinational from register.
//  - wb_we = valid & reg_write & (rd != 0). r0 never written; wb_rd/wb_data still driven.
//  - wb_data mux on registered wb_sel; sel 3 yields 0.
//  - Load data (wb_sel=1): byte offset = alu_result[1:0] (little-endian lanes, registered).
//    word: raw word. half: lane = off[1], off[0] ignored. byte: lane = off[1:0].
//    Sign-extend from lane MSB unless load_unsigned. For DATA_W>32, offset uses low 2 bits,
//    extension fills to DATA_W.
//  - Stall with valid=1: wb_we stays asserted with identical rd/data; a repeated identical
//    write is legal.
//  - retired_cnt increments by 1 on each posedge where in_valid & ~in_stall & ~in_flush;
//    wraps from all-ones to 0. Flush and stall in the same cycle: flush wins, no increment.
//  - Reset asserted mid-stall or mid-flush: reset wins, state cleared.
// CONFIGURATION
//  WB_LOAD_EXT_EN defined: sub-word load extraction/extension as above.
//  Not defined: load_size, load_unsigned and offset ignored; wb_sel=1 returns raw mem_rdata.
//  Ports unchanged in both builds.
// STRUCTURE
//  Shared package wb_pkg: WB_SEL_ALU/MEM/LINK/ZERO, LD_BYTE/HALF/WORD constants, typedef
//  of the MEM/WB register bundle. One sub-module: wb_load_align (combinational lane select
//  and sign/zero extension), instantiated only under WB_LOAD_EXT_EN.
// TESTING
//  1. reset=1 mid-run -> wb_we=0, wb_data=0, retired_cnt=0 without a clk edge.
//  2. ALU op rd=5, alu_result=0x1234_5678, wb_sel=0 -> next cycle wb_we=1, wb_rd=5,
//     wb_data=0x1234_5678; rd=0 same op -> wb_we=0.
//  3. mem_rdata=0x80FF_7F01: byte off=3 signed -> 0xFFFF_FF80; off=3 unsigned -> 0x80;
//     half off=2 signed -> 0xFFFF_80FF; half off=1 -> 0x7F01 (off[0] ignored).
//  4. Stall 3 cycles with valid instr, then flush+stall together -> outputs held 3 cycles,
//     then wb_valid=0, wb_we=0; retired_cnt +0 during these cycles.
//  5. CNT_W=4, 17 accepted instrs -> retired_cnt=1 (wrap); JAL wb_sel=2, link_pc=0x408,
//     rd=31 -> wb_data=0x408.
//  6. Build without WB_LOAD_EXT_EN: byte load off=3 -> wb_data=0x80FF_7F01.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and the control bundle held in the MEM/WB pipeline register.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;
  localparam logic [1:0] WB_SEL_ZERO = 2'd3;

  localparam logic [1:0] LD_BYTE = 2'd0;
  localparam logic [1:0] LD_HALF = 2'd1;
  localparam logic [1:0] LD_WORD = 2'd2;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] load_size;
    logic       load_unsigned;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM-to-WB bus: MEM-side instruction fields in, register-file write port and status out.
interface wb_stage_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  in_valid;
  logic                  in_stall;
  logic                  in_flush;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     link_pc;
  logic [REG_ADDR_W-1:0] rd;
  logic                  reg_write;
  logic [1:0]            wb_sel;
  logic [1:0]            load_size;
  logic                  load_unsigned;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;
  logic                  wb_valid;
  logic [CNT_W-1:0]      retired_cnt;

  modport master (
    output in_valid, in_stall, in_flush, mem_rdata, alu_result, link_pc,
           rd, reg_write, wb_sel, load_size, load_unsigned,
    input  wb_we, wb_rd, wb_data, wb_valid, retired_cnt
  );

  modport slave (
    input  in_valid, in_stall, in_flush, mem_rdata, alu_result, link_pc,
           rd, reg_write, wb_sel, load_size, load_unsigned,
    output wb_we, wb_rd, wb_data, wb_valid, retired_cnt
  );
endinterface

// File: rtl/wb_load_align.sv
// Little-endian lane select and sign/zero extension of a loaded word.
// Only instantiated when WB_LOAD_EXT_EN is defined.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (offset)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    // halfword lanes are naturally aligned; the low offset bit is ignored
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

    case (load_size)
      LD_BYTE: load_data = {{(DATA_W-8){~load_unsigned & lane_b[7]}}, lane_b};
      LD_HALF: load_data = {{(DATA_W-16){~load_unsigned & lane_h[15]}}, lane_h};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Write-back stage with MEM/WB register, source mux, r0 suppression and retire counter.
// Define WB_LOAD_EXT_EN to enable sub-word load extraction; otherwise loads pass raw.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          reset,
  wb_stage_pipe_if.slave bus
);

  logic                  valid_q;
  wb_ctrl_t              ctrl_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]     alu_q;
  logic [DATA_W-1:0]     mem_q;
  logic [DATA_W-1:0]     link_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     load_data;
  logic [DATA_W-1:0]     wb_data_c;
  logic                  accept;

  assign accept = bus.in_valid & ~bus.in_stall & ~bus.in_flush;

  // flush only drops valid; the captured fields keep their last values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
      link_q  <= '0;
    end else if (bus.in_flush) begin
      valid_q <= 1'b0;
    end else if (!bus.in_stall) begin
      valid_q              <= bus.in_valid;
      ctrl_q.reg_write     <= bus.reg_write;
      ctrl_q.wb_sel        <= bus.wb_sel;
      ctrl_q.load_size     <= bus.load_size;
      ctrl_q.load_unsigned <= bus.load_unsigned;
      rd_q                 <= bus.rd;
      alu_q                <= bus.alu_result;
      mem_q                <= bus.mem_rdata;
      link_q               <= bus.link_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef WB_LOAD_EXT_EN
  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .rdata         (mem_q),
    .offset        (alu_q[1:0]),
    .load_size     (ctrl_q.load_size),
    .load_unsigned (ctrl_q.load_unsigned),
    .load_data     (load_data)
  );
`else
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{ctrl_q.load_size, ctrl_q.load_unsigned};
  assign load_data        = mem_q;
`endif

  always_comb begin
    case (ctrl_q.wb_sel)
      WB_SEL_ALU:  wb_data_c = alu_q;
      WB_SEL_MEM:  wb_data_c = load_data;
      WB_SEL_LINK: wb_data_c = link_q;
      default:     wb_data_c = '0;
    endcase
  end

  assign bus.wb_we       = valid_q & ctrl_q.reg_write & (rd_q != '0);
  assign bus.wb_rd       = rd_q;
  assign bus.wb_data     = wb_data_c;
  assign bus.wb_valid    = valid_q;
  assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed self-checking bench for wb_stage_pipe (4-bit counter to exercise wrap).
// Load expectations follow whether WB_LOAD_EXT_EN is defined for this build.
module tb_wb_stage_pipe;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   ecnt;

  wb_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) bus ();

  wb_stage_pipe #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [1:0] lsz, input logic lun);
    bus.in_valid      = 1'b1;
    bus.reg_write     = 1'b1;
    bus.rd            = rd;
    bus.wb_sel        = sel;
    bus.alu_result    = alu;
    bus.load_size     = lsz;
    bus.load_unsigned = lun;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] off, input logic [1:0] lsz,
                          input logic lun, input logic [31:0] exp_ext);
    logic [31:0] exp;
    issue(5'd3, 2'd1, off, lsz, lun);
    step();
    ecnt++;
`ifdef WB_LOAD_EXT_EN
    exp = exp_ext;
`else
    exp = 32'h80FF_7F01;
`endif
    chk(tag, bus.wb_data, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ecnt  = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_stall = 1'b0; bus.in_flush = 1'b0;
    bus.mem_rdata = '0; bus.alu_result = '0; bus.link_pc = '0;
    bus.rd = '0; bus.reg_write = 1'b0; bus.wb_sel = '0;
    bus.load_size = '0; bus.load_unsigned = 1'b0;
    #2;
    chk("rst_we",    64'(bus.wb_we),       64'd0);
    chk("rst_valid", 64'(bus.wb_valid),    64'd0);
    chk("rst_data",  64'(bus.wb_data),     64'd0);
    chk("rst_cnt",   64'(bus.retired_cnt), 64'd0);
    #10;
    reset = 1'b0;

    issue(5'd5, 2'd0, 32'h1234_5678, 2'd2, 1'b0);
    step(); ecnt++;
    chk("alu_we",   64'(bus.wb_we),   64'd1);
    chk("alu_rd",   64'(bus.wb_rd),   64'd5);
    chk("alu_data", 64'(bus.wb_data), 64'h1234_5678);

    issue(5'd0, 2'd0, 32'h1234_5678, 2'd2, 1'b0);
    step(); ecnt++;
    chk("r0_we",   64'(bus.wb_we),   64'd0);
    chk("r0_data", 64'(bus.wb_data), 64'h1234_5678);
    chk("r0_cnt",  64'(bus.retired_cnt), 64'(ecnt % 16));

    bus.mem_rdata = 32'h80FF_7F01;
    load_chk("lb_off3_s",  32'h1003, 2'd0, 1'b0, 32'hFFFF_FF80);
    load_chk("lbu_off3",   32'h1003, 2'd0, 1'b1, 32'h0000_0080);
    load_chk("lh_off2_s",  32'h1002, 2'd1, 1'b0, 32'hFFFF_80FF);
    load_chk("lh_off1",    32'h1001, 2'd1, 1'b0, 32'h0000_7F01);
    load_chk("lw_off0",    32'h1000, 2'd2, 1'b0, 32'h80FF_7F01);

    issue(5'd31, 2'd2, 32'h0, 2'd2, 1'b0);
    bus.link_pc = 32'h408;
    step(); ecnt++;
    chk("jal_data", 64'(bus.wb_data), 64'h408);
    chk("jal_rd",   64'(bus.wb_rd),   64'd31);

    issue(5'd9, 2'd3, 32'hFFFF_FFFF, 2'd2, 1'b0);
    step(); ecnt++;
    chk("sel3_data", 64'(bus.wb_data), 64'd0);

    bus.in_valid = 1'b0;
    step();
    chk("idle_valid", 64'(bus.wb_valid),    64'd0);
    chk("idle_we",    64'(bus.wb_we),       64'd0);
    chk("idle_cnt",   64'(bus.retired_cnt), 64'(ecnt % 16));

    issue(5'd7, 2'd0, 32'hA5A5_0F0F, 2'd2, 1'b0);
    step(); ecnt++;
    bus.in_stall   = 1'b1;
    bus.alu_result = 32'hDEAD_BEEF;
    bus.rd         = 5'd12;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_we",   64'(bus.wb_we),       64'd1);
      chk("stall_rd",   64'(bus.wb_rd),       64'd7);
      chk("stall_data", 64'(bus.wb_data),     64'hA5A5_0F0F);
      chk("stall_cnt",  64'(bus.retired_cnt), 64'(ecnt % 16));
    end
    bus.in_flush = 1'b1;
    step();
    chk("flush_valid", 64'(bus.wb_valid),    64'd0);
    chk("flush_we",    64'(bus.wb_we),       64'd0);
    chk("flush_cnt",   64'(bus.retired_cnt), 64'(ecnt % 16));
    bus.in_stall = 1'b0;
    step();
    chk("flush2_valid", 64'(bus.wb_valid),    64'd0);
    chk("flush2_cnt",   64'(bus.retired_cnt), 64'(ecnt % 16));

    // reload, then assert reset between edges while stalled
    bus.in_flush = 1'b0;
    step(); ecnt++;
    chk("pre_rst_we", 64'(bus.wb_we), 64'd1);
    bus.in_stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_we",   64'(bus.wb_we),       64'd0);
    chk("mid_rst_data", 64'(bus.wb_data),     64'd0);
    chk("mid_rst_cnt",  64'(bus.retired_cnt), 64'd0);
    chk("mid_rst_rd",   64'(bus.wb_rd),       64'd0);
    #2;
    reset = 1'b0;
    bus.in_stall = 1'b0;
    ecnt = 0;

    for (int i = 0; i < 17; i++) begin
      issue(5'(i + 1), 2'd0, 32'(i * 3), 2'd2, 1'b0);
      step(); ecnt++;
      if (i == 14) chk("cnt_15", 64'(bus.retired_cnt), 64'd15);
      if (i == 15) chk("cnt_wrap0", 64'(bus.retired_cnt), 64'd0);
    end
    chk("cnt_wrap1", 64'(bus.retired_cnt), 64'(ecnt % 16));
    chk("last_data", 64'(bus.wb_data), 64'd48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
